wb_write_sched: RTL and testbench
=================================

Name: wb_write_sched

Overview:
- Sequences retiring instructions from the memory stage into a register file that has a single write port.
- Each instruction carries up to two results (valE → dstE, valM → dstM). The block serialises them as E first, then M, and back-pressures the memory stage while a second write is pending.
- It latches the first non-AOK status, stops the machine, and emits a retire pulse per instruction.
- Sits between the memory stage and the register file, replacing the pass-through writeback stage.

Parameters:
- DATA_W, 64, width of valE/valM and of the register file data.
- REG_AW, 4, register address width.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  memory stage presents an instruction; low means bubble.
- in_ready_o  out  1  block accepts the instruction this cycle.
- icode_i  in  4  instruction code; informational, used only for retire tagging.
- stat_i  in  3  instruction status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- dstE_i  in  REG_AW  E destination register.
- dstM_i  in  REG_AW  M destination register.
- valE_i  in  DATA_W  E result.
- valM_i  in  DATA_W  M result.
- rf_we_o  out  1  register file write enable (registered).
- rf_waddr_o  out  REG_AW  register file write address (registered).
- rf_wdata_o  out  DATA_W  register file write data (registered).
- retired_o  out  1  one-cycle pulse when an instruction completes all of its writes.
- retired_icode_o  out  4  icode of the retiring instruction; valid when retired_o is high.
- cpu_stat_o  out  3  architectural status.
- halted_o  out  1  high once a non-AOK status has been retired.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE, rf_we_o=0, rf_waddr_o=RNONE, rf_wdata_o=0.
  - retired_o=0, retired_icode_o=0, cpu_stat_o=1 (AOK), halted_o=0.
  - Pending-write registers are cleared; a pending M write is dropped.
  - in_ready_o is forced to 0 while rst_i is high.
- Handshake: accept = in_valid_i & in_ready_o. Inputs are sampled only on accept. in_ready_o = (state==IDLE) & !rst_i, decoded combinationally from state.
- States:
  - IDLE: ready; no pending write.
  - WR_M: M write pending; not ready.
  - HALTED: terminal until reset; not ready; no writes.
- Accept with stat_i==AOK (all writes appear the cycle after accept, T+1):
  - dstE valid (!=RNONE), dstM==RNONE: T+1 writes valE to dstE, retired_o=1; stay in IDLE.
  - dstE==RNONE, dstM valid: T+1 writes valM to dstM, retired_o=1.
  - Both valid and dstE!=dstM: T+1 writes E with retired_o=0 and the state goes to WR_M. T+2 writes M, retired_o=1, state returns to IDLE. Throughput is therefore 1 instruction per 2 cycles.
  - Both valid and dstE==dstM: a single write of valM at T+1 (M has priority), retired_o=1.
  - Neither valid: rf_we_o=0 and retired_o=1 at T+1.
- Accept with stat_i!=AOK:
  - No register write.
  - At T+1: cpu_stat_o=stat_i, halted_o=1, retired_o=1, state=HALTED.
  - Further in_valid_i is ignored until reset.
- rf_we_o and retired_o are single-cycle pulses; they are low in every cycle without a scheduled write or retire.
- rf_waddr_o and rf_wdata_o hold their last values when rf_we_o is low.
- A bubble (in_valid_i low) in IDLE produces no activity.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: adds output port retire_cnt_o (64 bits), a counter incremented on every retired_o pulse, including the halting instruction. It resets to 0 and wraps modulo 2^64.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package wb_pkg holds:
  - stat codes STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS.
  - RNONE.
  - FSM state encoding IDLE, WR_M, HALTED.
- No sub-module: the FSM plus pending registers is small enough for a single module.

Test Plan:
- Reset then one AOK instruction, dstE=4 (valE=0x10), dstM=RNONE → T+1: rf_we_o=1, addr=4, data=0x10, retired_o=1; in_ready_o stays 1.
- popq-style instruction, dstE=4 (valE=0x28), dstM=0 (valM=0xAB) → T+1 writes reg4=0x28 with retired_o=0 and in_ready_o=0. T+2 writes reg0=0xAB with retired_o=1. in_ready_o=1 at T+2.
- dstE=dstM=4, valE=0x1, valM=0x2 → a single write reg4=0x2 at T+1; no second write.
- stat_i=ADR with dstE=3 → no write; cpu_stat_o=3, halted_o=1, retired_o=1. in_ready_o=0; later valid inputs produce no writes.
- Reset asserted while in WR_M → pending M write never appears; outputs return to reset values. After reset is released, in_ready_o=1.
- With WB_RETIRE_CNT_EN: 5 single-write instructions followed by a HLT → retire_cnt_o=6 and cpu_stat_o=2.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - status codes, "no register" sentinel and FSM encoding for writeback
package wb_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_M   = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_write_sched.sv
// rtl/wb_write_sched.sv - serialises E/M results onto a single register-file write port
// Optional: WB_RETIRE_CNT_EN adds retire_cnt_o, a 64-bit retired-instruction counter.
module wb_write_sched
  import wb_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter int                REG_AW = 4,
  parameter logic [REG_AW-1:0] RNONE  = wb_pkg::RNONE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        icode_i,
  input  logic [2:0]        stat_i,
  input  logic [REG_AW-1:0] dstE_i,
  input  logic [REG_AW-1:0] dstM_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic [DATA_W-1:0] valM_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              retired_o,
  output logic [3:0]        retired_icode_o,
  output logic [2:0]        cpu_stat_o,
  output logic              halted_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt_o
`endif
);

  wb_state_t         state;
  logic [REG_AW-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [3:0]        pend_icode;

  logic e_valid;
  logic m_valid;

  assign in_ready_o = (state == IDLE) && !rst_i;
  assign e_valid    = (dstE_i != RNONE);
  assign m_valid    = (dstM_i != RNONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      rf_we_o         <= 1'b0;
      rf_waddr_o      <= RNONE;
      rf_wdata_o      <= '0;
      retired_o       <= 1'b0;
      retired_icode_o <= 4'd0;
      cpu_stat_o      <= STAT_AOK;
      halted_o        <= 1'b0;
      pend_addr       <= RNONE;
      pend_data       <= '0;
      pend_icode      <= 4'd0;
    end else begin
      rf_we_o   <= 1'b0;
      retired_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            if (stat_i != STAT_AOK) begin
              cpu_stat_o      <= stat_i;
              halted_o        <= 1'b1;
              retired_o       <= 1'b1;
              retired_icode_o <= icode_i;
              state           <= HALTED;
            end else if (e_valid && m_valid && (dstE_i != dstM_i)) begin
              // E goes out now; M is parked and the stage is stalled one cycle
              rf_we_o    <= 1'b1;
              rf_waddr_o <= dstE_i;
              rf_wdata_o <= valE_i;
              pend_addr  <= dstM_i;
              pend_data  <= valM_i;
              pend_icode <= icode_i;
              state      <= WR_M;
            end else begin
              // Same-register collision resolves to M, matching load-over-ALU order
              if (m_valid) begin
                rf_we_o    <= 1'b1;
                rf_waddr_o <= dstM_i;
                rf_wdata_o <= valM_i;
              end else if (e_valid) begin
                rf_we_o    <= 1'b1;
                rf_waddr_o <= dstE_i;
                rf_wdata_o <= valE_i;
              end
              retired_o       <= 1'b1;
              retired_icode_o <= icode_i;
            end
          end
        end
        WR_M: begin
          rf_we_o         <= 1'b1;
          rf_waddr_o      <= pend_addr;
          rf_wdata_o      <= pend_data;
          retired_o       <= 1'b1;
          retired_icode_o <= pend_icode;
          state           <= IDLE;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_cnt_o <= 64'd0;
    end else if (retired_o) begin
      retire_cnt_o <= retire_cnt_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_sched.sv
// tb/tb_wb_write_sched.sv - directed scoreboard bench for wb_write_sched
module tb_wb_write_sched;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [2:0]  stat;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] val_e;
  logic [63:0] val_m;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        retired;
  logic [3:0]  retired_icode;
  logic [2:0]  cpu_stat;
  logic        halted;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  wb_write_sched #(.DATA_W(64), .REG_AW(4), .RNONE(4'hF)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .icode_i        (icode),
    .stat_i         (stat),
    .dstE_i         (dst_e),
    .dstM_i         (dst_m),
    .valE_i         (val_e),
    .valM_i         (val_m),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .retired_o      (retired),
    .retired_icode_o(retired_icode),
    .cpu_stat_o     (cpu_stat),
    .halted_o       (halted)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o   (retire_cnt)
`endif
  );

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [63:0] data;
    logic        ret;
    logic [3:0]  icode;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Every write or retire pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (rf_we === 1'b1 || retired === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_event", {62'd0, rf_we, retired}, 64'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("ev_we", 64'(rf_we), 64'(e.we));
        check("ev_retired", 64'(retired), 64'(e.ret));
        if (e.we) begin
          check("ev_waddr", 64'(rf_waddr), 64'(e.addr));
          check("ev_wdata", rf_wdata, e.data);
        end
        if (e.ret) check("ev_icode", 64'(retired_icode), 64'(e.icode));
      end
    end
  end

  task automatic push(input logic we, input logic [3:0] a, input logic [63:0] d,
                      input logic r, input logic [3:0] ic);
    ev_t e;
    e.we = we; e.addr = a; e.data = d; e.ret = r; e.icode = ic;
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] ic, input logic [2:0] st, input logic [3:0] de,
                      input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    int budget = 0;
    while (in_ready !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1; icode = ic; stat = st;
    dst_e = de; dst_m = dm; val_e = ve; val_m = vm;
    if (st != STAT_AOK) push(1'b0, 4'h0, 64'd0, 1'b1, ic);
    else if (de != RNONE && dm != RNONE && de != dm) begin
      push(1'b1, de, ve, 1'b0, ic);
      push(1'b1, dm, vm, 1'b1, ic);
    end
    else if (dm != RNONE) push(1'b1, dm, vm, 1'b1, ic);
    else if (de != RNONE) push(1'b1, de, ve, 1'b1, ic);
    else push(1'b0, 4'h0, 64'd0, 1'b1, ic);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_we"}, 64'(rf_we), 64'd0);
    check({pfx, "_waddr"}, 64'(rf_waddr), 64'hF);
    check({pfx, "_wdata"}, rf_wdata, 64'd0);
    check({pfx, "_retired"}, 64'(retired), 64'd0);
    check({pfx, "_icode"}, 64'(retired_icode), 64'd0);
    check({pfx, "_stat"}, 64'(cpu_stat), 64'd1);
    check({pfx, "_halted"}, 64'(halted), 64'd0);
    check({pfx, "_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) begin @(posedge clk); #1; end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; icode = 4'h0; stat = STAT_AOK;
    dst_e = 4'hF; dst_m = 4'hF; val_e = 64'd0; val_m = 64'd0;
    repeat (2) begin @(posedge clk); #1; end
    check_reset_outputs("reset");
    rst = 1'b0; #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Single E write keeps the stage ready
    send(4'h6, STAT_AOK, 4'd4, 4'hF, 64'h10, 64'h0);
    check("single_e_ready", 64'(in_ready), 64'd1);

    // popq-style dual write stalls for one cycle
    send(4'hB, STAT_AOK, 4'd4, 4'd0, 64'h28, 64'hAB);
    check("dual_stall_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("dual_release_ready", 64'(in_ready), 64'd1);

    // Same destination: M wins, one write only
    send(4'h5, STAT_AOK, 4'd4, 4'd4, 64'h1, 64'h2);
    send(4'h5, STAT_AOK, 4'hF, 4'd9, 64'h77, 64'h1234_5678_9ABC_DEF0);
    send(4'h1, STAT_AOK, 4'hF, 4'hF, 64'h55, 64'h66);
    send(4'hB, STAT_AOK, 4'd14, 4'd1, {$urandom, $urandom}, {$urandom, $urandom});
    send(4'h2, STAT_AOK, 4'd2, 4'hF, {$urandom, $urandom}, 64'h0);
    drain("drain_aok");

    // Faulting instruction halts the machine
    send(4'h5, STAT_ADR, 4'd3, 4'hF, 64'h33, 64'h0);
    check("adr_stat", 64'(cpu_stat), 64'(STAT_ADR));
    check("adr_halted", 64'(halted), 64'd1);
    check("adr_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; stat = STAT_AOK; dst_e = 4'd7; dst_m = 4'hF; val_e = 64'h99;
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("halted_stat_hold", 64'(cpu_stat), 64'(STAT_ADR));
    drain("drain_halted");

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("ready_after_halt_reset", 64'(in_ready), 64'd1);

    // Reset while the M write is pending drops it
    send(4'hB, STAT_AOK, 4'd5, 4'd6, 64'hE5, 64'hF6);
    sb.pop_back();
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("wrm_reset");
    rst = 1'b0; #1;
    check("ready_after_wrm_reset", 64'(in_ready), 64'd1);
    drain("drain_wrm_reset");

    for (int i = 0; i < 5; i++)
      send(4'h2, STAT_AOK, 4'($urandom_range(0, 14)), 4'hF, {$urandom, $urandom}, 64'h0);
    send(4'h0, STAT_HLT, 4'hF, 4'hF, 64'h0, 64'h0);
    drain("drain_hlt");
    check("hlt_stat", 64'(cpu_stat), 64'(STAT_HLT));
    check("hlt_halted", 64'(halted), 64'd1);
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, 64'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
